// File: rtl/transmitter_if.sv
// Symbol handshake and channel-level bundle between a symbol source and the transmitter.
interface transmitter_if;
    logic [3:0]  sym_in;
    logic        sym_valid;
    logic        sym_ready;
    logic [15:0] data_out1;
    logic [15:0] data_out2;
    logic [15:0] data_out3;
    logic [15:0] data_out4;
    logic        out_valid;
    logic [15:0] word_cnt;

    modport master (
        output sym_in, sym_valid,
        input  sym_ready, data_out1, data_out2, data_out3, data_out4, out_valid, word_cnt
    );

    modport slave (
        input  sym_in, sym_valid,
        output sym_ready, data_out1, data_out2, data_out3, data_out4, out_valid, word_cnt
    );
endinterface

// File: rtl/transmitter.sv
// Four-channel symbol transmitter: FIFO-buffered 4-bit words emitted as sign-magnitude levels.
// Define TX_NOISE_EN to add LFSR nibbles to the emitted magnitudes.
//
// state | meaning
// IDLE  | nothing on the outputs, waiting for a queued word
// SEND  | a word is held on the outputs for HOLD cycles
module transmitter #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1
) (
    input logic          clk,
    input logic          rst,
    transmitter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_TC = HW'(HOLD - 1);
    localparam logic [15:0] POS = 16'h0001;
    localparam logic [15:0] NEG = 16'h8000;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [HW-1:0] hold_cnt;
    logic [15:0]   dout [4];
    logic [15:0]   next_level [4];
    logic          out_valid_q;
    logic [15:0]   word_cnt_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [3:0]    head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.sym_valid && !full;
    assign pop   = !empty && (state == IDLE || hold_cnt == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

`ifdef TX_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (pop)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Noise nibble rides on the magnitude only; worst case 1 + 15 fits easily.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            next_level[c]       = head[c] ? POS : NEG;
            next_level[c][14:0] = (head[c] ? 15'd1 : 15'd0) + {11'd0, lfsr[4*c +: 4]};
        end
    end
`else
    always_comb begin
        for (int c = 0; c < 4; c++)
            next_level[c] = head[c] ? POS : NEG;
    end
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= bus.sym_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int c = 0; c < 4; c++) dout[c] <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        dout        <= next_level;
                        hold_cnt    <= HOLD_TC;
                        out_valid_q <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (pop) begin
                        dout     <= next_level;
                        hold_cnt <= HOLD_TC;
                    end else begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                        for (int c = 0; c < 4; c++) dout[c] <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sym_ready = !full;
    assign bus.data_out1 = dout[0];
    assign bus.data_out2 = dout[1];
    assign bus.data_out3 = dout[2];
    assign bus.data_out4 = dout[3];
    assign bus.out_valid = out_valid_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule

// File: doc/transmitter.md
# transmitter

Transmit-side counterpart of the four-channel receiver: accepts 4-bit symbol words over a valid/ready handshake, buffers them in a small FIFO, and drives each bit as a 16-bit sign-magnitude level on one of four parallel channel outputs (`data_out1`..`data_out4`). It feeds the receiver's `data_in1`..`data_in4` in the FPGA loopback and test setups. An optional LFSR noise source perturbs the emitted magnitudes, exercising the receiver's noise filtering in hardware.

## Interface
- `DEPTH`, 4, symbol FIFO depth in entries; power of two, ≥2.
- `HOLD`, 1, cycles each symbol word is held on the outputs; ≥1.
- `clk`  input  1  single clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `sym_in`  input  4  symbol word; bit0→ch1 … bit3→ch4; 1 = +1, 0 = −1.
- `sym_valid`  input  1  `sym_in` valid this cycle.
- `sym_ready`  output  1  FIFO can accept; equals !full, combinational from state.
- `data_out1`..`data_out4`  output  16 each  channel levels, registered.
- `out_valid`  output  1  high while a symbol word is being held on the outputs.
- `word_cnt`  output  16  count of words emitted; wraps 0xFFFF→0x0000.

## Operation
- Level encoding (sign-magnitude, bit15 = sign, bits14:0 = magnitude):
  - +1 → `POS` = 16'h0001.
  - −1 → `NEG` = 16'h8000.
- FIFO:
  - Push on `sym_valid && sym_ready`.
  - No push when full, even if a pop occurs in the same cycle.
  - Pointers are log2(DEPTH)+1 bits wide so full and empty are distinguished.
- FSM states:
  - IDLE: `out_valid`=0 and all `data_out`=0. If FIFO non-empty: pop, load the output registers, hold_cnt←HOLD−1, go to SEND.
  - SEND: `out_valid`=1.
    - hold_cnt≠0: decrement.
    - hold_cnt=0 and FIFO non-empty: pop next word, reload outputs and hold_cnt, stay in SEND.
    - hold_cnt=0 and FIFO empty: go to IDLE, zero the outputs.
- `word_cnt` increments on every pop.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.

## Timing
- Reset values:
  - `data_out1`..`data_out4` = 0, `out_valid` = 0, `word_cnt` = 0.
  - FIFO empty, so `sym_ready` = 1.
  - FSM in IDLE, hold_cnt = 0, LFSR = 16'hACE1.
- Latency, empty FIFO in IDLE: word accepted at edge k is popped at edge k+1. Outputs and `out_valid` are visible from edge k+1 until edge k+1+HOLD.
- Back-to-back: with the FIFO non-empty, consecutive words occupy exactly HOLD cycles each with no `out_valid` gap.
- Full: `sym_ready` drops in the cycle after the DEPTH-th unpopped push. It rises the cycle after a pop.
- Reset asserted mid-operation: all state returns to reset values at that edge. Queued words are discarded and not emitted.

## Configuration
- `TX_NOISE_EN` defined:
  - A 16-bit Galois LFSR (mask 16'hB400, seed 16'hACE1) advances once per pop.
  - Nibble `lfsr[4c+3:4c]`, taken before the advance, is added to the magnitude of channel c (c=0..3 for ch1..ch4).
  - Sign is unchanged. Maximum magnitude is 16, so no overflow handling is needed.
- `TX_NOISE_EN` undefined:
  - No LFSR is instantiated.
  - Outputs are exactly `POS`/`NEG`.

## Test plan
- Reset → all `data_out`=0, `out_valid`=0, `word_cnt`=0, `sym_ready`=1.
- Single word 4'b1010, HOLD=1, noise off:
  - Required response: one cycle after acceptance, ch1=16'h8000, ch2=16'h0001, ch3=16'h8000, ch4=16'h0001, `out_valid`=1 for exactly 1 cycle, then IDLE with outputs 0, `word_cnt`=1.
- Push 6 words back-to-back, DEPTH=4, HOLD=3:
  - Required flow control: `sym_ready` low once 4 words are queued.
  - Required output: words emitted in order, 3 cycles each, no gaps; `word_cnt`=6 at end.
- Sustained push with simultaneous pop at full-1 occupancy:
  - Required response: occupancy constant, no word lost or duplicated (scoreboard compare).
- Reset asserted while in SEND with 3 words queued → next cycle all reset values; no queued word ever appears.
- `TX_NOISE_EN` defined, first word 4'b1111 after reset (LFSR 16'hACE1):
  - Required response: ch1=16'h0002, ch2=16'h000F, ch3=16'h000D, ch4=16'h000B.
  - LFSR steps to its next value after the pop.
